aidc_lite_comp_engine_ctrl: RTL and testbench



---
 rtl/aidc_lite_comp_pkg.sv | 25 ++
 rtl/aidc_lite_wr_slot.sv | 33 +++
 rtl/aidc_lite_comp_engine_ctrl.sv | 157 +++++++++++++++
 tb/tb_aidc_lite_comp_engine_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aidc_lite_comp_pkg.sv
// Shared types and constants for the lite compression engine sequencer.
// Holds the FSM state encoding, block geometry and the write-request payload.
package aidc_lite_comp_pkg;

    localparam int unsigned BLK_BYTES    = 128;
    localparam int unsigned BLK_SHIFT    = 7;
    localparam logic [7:0]  MAX_BLK_SIZE = 8'd128;
    localparam logic [31:0] SRC_MASK     = ~(32'(BLK_BYTES) - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  size;
    } wr_req_t;

    function automatic logic size_illegal(input logic [7:0] size);
        return (size == 8'd0) || (size > MAX_BLK_SIZE);
    endfunction

endpackage

// File: rtl/aidc_lite_wr_slot.sv
// Single-entry valid/ready holding register for one packed write request.
// Loaded only while empty; empties on the downstream handshake.
module aidc_lite_wr_slot
    import aidc_lite_comp_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_load,
    input  wr_req_t i_req,
    input  logic    i_ready,
    output logic    o_valid,
    output wr_req_t o_req
);

    logic    r_valid;
    wr_req_t r_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_req   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_req   <= i_req;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_req   = r_req;

endmodule

// File: rtl/aidc_lite_comp_engine_ctrl.sv
// Compression job sequencer: issues 128B source reads with bounded run-ahead and
// packs per-block compressed results into writes at a running destination pointer.
module aidc_lite_comp_engine_ctrl
    import aidc_lite_comp_pkg::*;
#(
    parameter int unsigned RD_OUTSTANDING = 2,
    parameter int unsigned CNT_W          = 25
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] src_addr_i,
    input  logic [31:0] dst_addr_i,
    input  logic [24:0] len_i,
    input  logic        start_i,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] comp_len_o,
    output logic        rd_req_valid_o,
    input  logic        rd_req_ready_i,
    output logic [31:0] rd_req_addr_o,
    input  logic        blk_valid_i,
    output logic        blk_ready_o,
    input  logic [7:0]  blk_size_i,
    output logic        wr_req_valid_o,
    input  logic        wr_req_ready_i,
    output logic [31:0] wr_req_addr_o,
    output logic [7:0]  wr_req_size_o
);

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_len, r_rd_cnt, r_blk_cnt, r_wr_cnt;
    logic [CNT_W-1:0] w_len_nxt, w_rd_cnt_nxt, w_blk_cnt_nxt, w_wr_cnt_nxt, w_outstanding;
    logic [31:0]      r_src, r_dst_ptr, r_comp_len, r_rd_addr;
    logic [31:0]      w_src_nxt, w_dst_nxt, w_comp_len_nxt, w_rd_addr_nxt;
    logic             r_done, r_err, r_rd_valid, r_blk_ready;
    logic             w_done_nxt, w_err_nxt, w_rd_valid_nxt, w_blk_ready_nxt;
    logic             w_rd_hs, w_blk_hs, w_wr_hs, w_wr_valid, w_wr_valid_nxt, w_size_bad;
    logic [7:0]       w_size;
    wr_req_t          w_wr_load_req, w_wr_req;

    assign w_rd_hs       = r_rd_valid & rd_req_ready_i;
    assign w_blk_hs      = r_blk_ready & blk_valid_i;
    assign w_wr_hs       = w_wr_valid & wr_req_ready_i;
    assign w_size_bad    = size_illegal(blk_size_i);
    assign w_size        = w_size_bad ? MAX_BLK_SIZE : blk_size_i;
    assign w_wr_load_req = '{addr: r_dst_ptr, size: w_size};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_rd_cnt    <= '0;
            r_blk_cnt   <= '0;
            r_wr_cnt    <= '0;
            r_src       <= '0;
            r_dst_ptr   <= '0;
            r_comp_len  <= '0;
            r_rd_addr   <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_blk_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_rd_cnt    <= w_rd_cnt_nxt;
            r_blk_cnt   <= w_blk_cnt_nxt;
            r_wr_cnt    <= w_wr_cnt_nxt;
            r_src       <= w_src_nxt;
            r_dst_ptr   <= w_dst_nxt;
            r_comp_len  <= w_comp_len_nxt;
            r_rd_addr   <= w_rd_addr_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_rd_valid  <= w_rd_valid_nxt;
            r_blk_ready <= w_blk_ready_nxt;
        end
    end

    // Next-state, counters and registered request controls computed from next-cycle values
    always_comb begin
        w_state_nxt    = r_state;
        w_len_nxt      = r_len;
        w_src_nxt      = r_src;
        w_dst_nxt      = r_dst_ptr;
        w_comp_len_nxt = r_comp_len;
        w_done_nxt     = r_done;
        w_err_nxt      = r_err;
        w_rd_cnt_nxt   = r_rd_cnt + CNT_W'(w_rd_hs);
        w_blk_cnt_nxt  = r_blk_cnt + CNT_W'(w_blk_hs);
        w_wr_cnt_nxt   = r_wr_cnt + CNT_W'(w_wr_hs);

        if (w_blk_hs) begin
            w_dst_nxt      = r_dst_ptr + 32'(w_size);
            w_comp_len_nxt = r_comp_len + 32'(w_size);
            w_err_nxt      = r_err | w_size_bad;
        end

        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_src_nxt      = src_addr_i & SRC_MASK;
                    w_dst_nxt      = dst_addr_i;
                    w_len_nxt      = CNT_W'(len_i);
                    w_rd_cnt_nxt   = '0;
                    w_blk_cnt_nxt  = '0;
                    w_wr_cnt_nxt   = '0;
                    w_comp_len_nxt = '0;
                    w_done_nxt     = 1'b0;
                    w_err_nxt      = 1'b0;
                    w_state_nxt    = (len_i == 25'd0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                // Completion is flagged on the edge of the final write handshake
                if (w_wr_cnt_nxt == r_len) begin
                    w_state_nxt = ST_FIN;
                    w_done_nxt  = 1'b1;
                end
            end
            ST_FIN: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_wr_valid_nxt  = w_blk_hs | (w_wr_valid & ~wr_req_ready_i);
        w_outstanding   = w_rd_cnt_nxt - w_blk_cnt_nxt;
        w_rd_valid_nxt  = (w_state_nxt == ST_RUN) && (w_rd_cnt_nxt < w_len_nxt) &&
                          (w_outstanding < CNT_W'(RD_OUTSTANDING));
        w_blk_ready_nxt = (w_state_nxt == ST_RUN) && !w_wr_valid_nxt &&
                          (w_rd_cnt_nxt != w_blk_cnt_nxt);
        w_rd_addr_nxt   = w_src_nxt + (32'(w_rd_cnt_nxt) << BLK_SHIFT);
    end

    aidc_lite_wr_slot u_wr_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_blk_hs),
        .i_req   (w_wr_load_req),
        .i_ready (wr_req_ready_i),
        .o_valid (w_wr_valid),
        .o_req   (w_wr_req)
    );

    assign done_o         = r_done;
    assign err_o          = r_err;
    assign comp_len_o     = r_comp_len;
    assign rd_req_valid_o = r_rd_valid;
    assign rd_req_addr_o  = r_rd_addr;
    assign blk_ready_o    = r_blk_ready;
    assign wr_req_valid_o = w_wr_valid;
    assign wr_req_addr_o  = w_wr_req.addr;
    assign wr_req_size_o  = w_wr_req.size;

endmodule

// File: tb/tb_aidc_lite_comp_engine_ctrl.sv
// Scoreboard bench for the compression job sequencer: a job-level model fills
// expected read/write queues; a monitor pops and compares on every handshake.
module tb_aidc_lite_comp_engine_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] src_addr_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic [24:0] len_i = '0;
    logic        start_i = 1'b0;
    logic        done_o, err_o;
    logic [31:0] comp_len_o;
    logic        rd_req_valid_o;
    logic        rd_req_ready_i = 1'b0;
    logic [31:0] rd_req_addr_o;
    logic        blk_valid_i = 1'b0;
    logic        blk_ready_o;
    logic [7:0]  blk_size_i = '0;
    logic        wr_req_valid_o;
    logic        wr_req_ready_i = 1'b0;
    logic [31:0] wr_req_addr_o;
    logic [7:0]  wr_req_size_o;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_wa_q[$];
    int          exp_ws_q[$];
    int          job_sizes[$];
    int          job_len = 0;
    int          rd_seen = 0;
    int          wr_seen = 0;
    bit          chk_done = 1'b0;
    logic [31:0] exp_comp_len = '0;
    logic        exp_err = 1'b0;
    bit          rd_rand = 1'b0, wr_rand = 1'b0, blk_rand = 1'b0, blk_en = 1'b0;
    bit          rd_rdy_f = 1'b1, wr_rdy_f = 1'b1;
    int          blk_idx = 0;
    bit          blk_hs = 1'b0;

    always #5 clk = ~clk;

    aidc_lite_comp_engine_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src_addr_i     (src_addr_i),
        .dst_addr_i     (dst_addr_i),
        .len_i          (len_i),
        .start_i        (start_i),
        .done_o         (done_o),
        .err_o          (err_o),
        .comp_len_o     (comp_len_o),
        .rd_req_valid_o (rd_req_valid_o),
        .rd_req_ready_i (rd_req_ready_i),
        .rd_req_addr_o  (rd_req_addr_o),
        .blk_valid_i    (blk_valid_i),
        .blk_ready_o    (blk_ready_o),
        .blk_size_i     (blk_size_i),
        .wr_req_valid_o (wr_req_valid_o),
        .wr_req_ready_i (wr_req_ready_i),
        .wr_req_addr_o  (wr_req_addr_o),
        .wr_req_size_o  (wr_req_size_o)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compressor and downstream responders; inputs change 1ns after the rising edge
    always begin
        @(negedge clk);
        blk_hs = rst_n && blk_valid_i && blk_ready_o;
        @(posedge clk);
        #1;
        if (blk_hs) blk_idx++;
        rd_req_ready_i = rd_rand ? 1'($urandom_range(0, 1)) : rd_rdy_f;
        wr_req_ready_i = wr_rand ? 1'($urandom_range(0, 1)) : wr_rdy_f;
        if (blk_en && blk_idx < job_sizes.size() && (!blk_rand || $urandom_range(0, 2) != 0)) begin
            blk_valid_i = 1'b1;
            blk_size_i  = 8'(job_sizes[blk_idx]);
        end else begin
            blk_valid_i = 1'b0;
            blk_size_i  = 8'($urandom);
        end
    end

    // Monitor: compare every read/write handshake against the expected queues
    always @(negedge clk) begin
        if (chk_done) begin
            check("done_after_last_wr", 32'(done_o), 32'd1);
            chk_done = 1'b0;
        end
        if (rst_n && rd_req_valid_o && rd_req_ready_i) begin
            rd_seen++;
            if (exp_rd_q.size() == 0) check("rd_unexpected", 32'(rd_req_valid_o), 32'd0);
            else check("rd_addr", rd_req_addr_o, exp_rd_q.pop_front());
        end
        if (rst_n && wr_req_valid_o && wr_req_ready_i) begin
            wr_seen++;
            if (exp_wa_q.size() == 0) begin
                check("wr_unexpected", 32'(wr_req_valid_o), 32'd0);
            end else begin
                check("wr_addr", wr_req_addr_o, exp_wa_q.pop_front());
                check("wr_size", 32'(wr_req_size_o), 32'(exp_ws_q.pop_front()));
            end
            if (wr_seen == job_len) chk_done = 1'b1;
        end
    end

    task automatic gen_sizes(input int len, input bit illegal_ok);
        job_sizes.delete();
        for (int i = 0; i < len; i++) begin
            if (illegal_ok && $urandom_range(0, 7) == 0)
                job_sizes.push_back(($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(129, 255)));
            else
                job_sizes.push_back(int'($urandom_range(1, 128)));
        end
    endtask

    // Job-level model: reads walk 128B blocks, writes pack clamped sizes back to back
    task automatic start_job(input logic [31:0] src, input logic [31:0] dst, input int len);
        logic [31:0] ptr;
        int          cs;
        exp_rd_q.delete();
        exp_wa_q.delete();
        exp_ws_q.delete();
        for (int i = 0; i < len; i++)
            exp_rd_q.push_back((src & 32'hFFFF_FF80) + 32'(i) * 32'd128);
        ptr = dst;
        exp_comp_len = '0;
        exp_err = 1'b0;
        for (int i = 0; i < len; i++) begin
            cs = job_sizes[i];
            if (cs == 0 || cs > 128) begin
                cs = 128;
                exp_err = 1'b1;
            end
            exp_wa_q.push_back(ptr);
            exp_ws_q.push_back(cs);
            ptr = ptr + 32'(cs);
            exp_comp_len = exp_comp_len + 32'(cs);
        end
        job_len = len;
        rd_seen = 0;
        wr_seen = 0;
        blk_idx = 0;
        @(posedge clk);
        #1;
        src_addr_i = src;
        dst_addr_i = dst;
        len_i      = 25'(len);
        start_i    = 1'b1;
        @(posedge clk);
        #1;
        start_i    = 1'b0;
        src_addr_i = $urandom;
        dst_addr_i = $urandom;
        len_i      = 25'($urandom);
    endtask

    task automatic finish_job(input string nm);
        int n = 0;
        while (done_o !== 1'b1 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_done"}, 32'(done_o), 32'd1);
        check({nm, "_comp_len"}, comp_len_o, exp_comp_len);
        check({nm, "_err"}, 32'(err_o), 32'(exp_err));
        check({nm, "_rd_count"}, 32'(rd_seen), 32'(job_len));
        check({nm, "_wr_count"}, 32'(wr_seen), 32'(job_len));
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_comp_len", comp_len_o, 32'd0);
        check("rst_rd_valid", 32'(rd_req_valid_o), 32'd0);
        check("rst_blk_ready", 32'(blk_ready_o), 32'd0);
        check("rst_wr_valid", 32'(wr_req_valid_o), 32'd0);
        rst_n = 1'b1;
        blk_en = 1'b1;

        // Basic three-block job with all readies high
        job_sizes = '{40, 128, 1};
        start_job(32'h0000_1000, 32'h0000_8000, 3);
        finish_job("basic");
        check("basic_169", comp_len_o, 32'd169);

        // Run-ahead limit with no compressor results
        blk_en = 1'b0;
        gen_sizes(5, 1'b0);
        start_job(32'h0000_4000, 32'h0000_0100, 5);
        repeat (10) @(negedge clk);
        check("runahead_rd_count", 32'(rd_seen), 32'd2);
        check("runahead_rd_valid", 32'(rd_req_valid_o), 32'd0);
        check("runahead_rd_addr", rd_req_addr_o, 32'h0000_4100);
        blk_en = 1'b1;
        finish_job("runahead");

        // Write backpressure: holding register full blocks further results
        wr_rdy_f = 1'b0;
        gen_sizes(4, 1'b0);
        start_job(32'h0000_0000, 32'h0000_2000, 4);
        n = 0;
        while (!wr_req_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_wr_valid", 32'(wr_req_valid_o), 32'd1);
        repeat (10) begin
            @(negedge clk);
            check("bp_blk_ready", 32'(blk_ready_o), 32'd0);
            check("bp_wr_addr", wr_req_addr_o, 32'h0000_2000);
            check("bp_wr_size", 32'(wr_req_size_o), 32'(job_sizes[0]));
        end
        wr_rdy_f = 1'b1;
        n = 0;
        while (!(wr_req_valid_o && wr_req_ready_i) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_release_hs", 32'(wr_req_valid_o & wr_req_ready_i), 32'd1);
        @(negedge clk);
        check("bp_blk_ready_after_wr", 32'(blk_ready_o), 32'd1);
        finish_job("bp");

        // Zero-length job
        job_sizes.delete();
        start_job(32'h0000_5000, 32'h0000_6000, 0);
        @(negedge clk);
        check("len0_done_low", 32'(done_o), 32'd0);
        check("len0_rd_valid", 32'(rd_req_valid_o), 32'd0);
        @(negedge clk);
        check("len0_done_high", 32'(done_o), 32'd1);
        check("len0_comp_len", comp_len_o, 32'd0);
        check("len0_wr_valid", 32'(wr_req_valid_o), 32'd0);

        // Illegal sizes clamp to 128 and set the sticky error
        job_sizes = '{0, 50, 200};
        start_job(32'h0000_A000, 32'h0001_0000, 3);
        finish_job("illegal");
        job_sizes = '{10};
        start_job(32'h0000_B000, 32'h0002_0000, 1);
        @(negedge clk);
        check("err_cleared", 32'(err_o), 32'd0);
        finish_job("after_err");

        // Mid-run start is ignored; destination wraps
        gen_sizes(4, 1'b0);
        job_sizes[0] = 128;
        start_job(32'h0000_2000, 32'hFFFF_FFC0, 4);
        repeat (3) @(posedge clk);
        #1;
        src_addr_i = 32'h0000_7000;
        dst_addr_i = 32'h0000_0000;
        len_i      = 25'd9;
        start_i    = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        finish_job("midstart");

        // Asynchronous reset during a run
        rd_rdy_f = 1'b0;
        blk_en   = 1'b0;
        gen_sizes(6, 1'b0);
        start_job(32'h0000_3000, 32'h0000_3000, 6);
        n = 0;
        while (!rd_req_valid_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rstrun_rd_valid_before", 32'(rd_req_valid_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstrun_rd_valid", 32'(rd_req_valid_o), 32'd0);
        check("rstrun_wr_valid", 32'(wr_req_valid_o), 32'd0);
        check("rstrun_blk_ready", 32'(blk_ready_o), 32'd0);
        check("rstrun_done", 32'(done_o), 32'd0);
        exp_rd_q.delete();
        exp_wa_q.delete();
        exp_ws_q.delete();
        job_len = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        rd_rdy_f = 1'b1;
        blk_en   = 1'b1;
        gen_sizes(3, 1'b0);
        start_job(32'h0001_0000, 32'h0002_0000, 3);
        finish_job("after_rst");

        // Randomised jobs with random handshakes, sizes and wrap-prone pointers
        rd_rand  = 1'b1;
        wr_rand  = 1'b1;
        blk_rand = 1'b1;
        for (int k = 0; k < 25; k++) begin
            int          len;
            logic [31:0] src, dst;
            len = int'($urandom_range(1, 10));
            src = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FE00 | 32'($urandom_range(0, 511))) : $urandom;
            dst = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : $urandom;
            gen_sizes(len, 1'b1);
            start_job(src, dst, len);
            finish_job("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
